// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage immediate extractor/extender with valid/ready handshake.
// Stage 1 holds the extracted, extended field with its shift amount and error flag.
// Stage 2 holds the final shifted immediate presented to the consumer.
module imm_ext_pipe #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         fmt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  imm,
  output logic               err
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_D  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_CB = 3'd3;
  localparam logic [2:0] FMT_IW = 3'd4;

  logic [63:0]       w_ext64;
  logic [DATA_W-1:0] w_field;
  logic [5:0]        w_shamt;
  logic              w_err;
  logic              w_s1Advance;
  logic              w_accept;
  logic              w_unusedBits;

  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1Field;
  logic [5:0]        r_s1Shamt;
  logic              r_s1Err;

  logic              r_s2Valid;
  logic [DATA_W-1:0] r_imm;
  logic              r_err;

  // Decode the format: build the field at full 64-bit width, pick the shift, flag illegal cases.
  always_comb begin
    w_ext64 = '0;
    w_shamt = '0;
    w_err   = 1'b0;
    case (fmt)
      FMT_I:  w_ext64 = {52'b0, instr[21:10]};
      FMT_D:  w_ext64 = {{55{instr[20]}}, instr[20:12]};
      FMT_B: begin
        w_ext64 = {{38{instr[25]}}, instr[25:0]};
        w_shamt = 6'd2;
      end
      FMT_CB: begin
        w_ext64 = {{45{instr[23]}}, instr[23:5]};
        w_shamt = 6'd2;
      end
      FMT_IW: begin
        // A 32-bit datapath cannot hold halfword positions 2 and 3, so those become errors.
        if ((DATA_W == 32) && instr[22]) begin
          w_err = 1'b1;
        end else begin
          w_ext64 = {48'b0, instr[20:5]};
          w_shamt = {instr[22:21], 4'b0000};
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // Truncation to the datapath width happens here; instruction bits above 25 carry no immediate.
  assign w_field      = w_ext64[DATA_W-1:0];
  assign w_unusedBits = ^{instr[INSTR_W-1:26], w_ext64};

  // Stage 1 may move forward whenever stage 2 is empty or being drained this cycle.
  assign w_s1Advance = !r_s2Valid || out_ready;
  assign in_ready    = !reset && !flush && (!r_s1Valid || w_s1Advance);
  assign w_accept    = in_valid && in_ready;

  // Stage 1: capture the decoded field on accept, hold it while stage 2 is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Field <= '0;
      r_s1Shamt <= '0;
      r_s1Err   <= 1'b0;
    end else if (flush) begin
      r_s1Valid <= 1'b0;
    end else if (!r_s1Valid || w_s1Advance) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Field <= w_field;
        r_s1Shamt <= w_shamt;
        r_s1Err   <= w_err;
      end
    end
  end

  // Stage 2: apply the shift and present the result; imm/err only change when stage 1 advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2Valid <= 1'b0;
      r_imm     <= '0;
      r_err     <= 1'b0;
    end else if (flush) begin
      r_s2Valid <= 1'b0;
    end else if (w_s1Advance) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_imm <= r_s1Field << r_s1Shamt;
        r_err <= r_s1Err;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign imm       = r_imm;
  assign err       = r_err;

endmodule
